// File: rtl/tl_tx_fc_scheduler.sv
// Credit-aware round-robin TLP scheduler: grants one source at a time when the
// DLL has advertised enough header/data credits, then waits for the TLP to finish.
module tl_tx_fc_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int FC_HDR_WIDTH  = 8,
  parameter int FC_DATA_WIDTH = 12,
  parameter int DCRED_WIDTH   = 9
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [2*NUM_REQ-1:0]           req_type,
  input  logic [DCRED_WIDTH*NUM_REQ-1:0] req_dcred,
  input  logic                           tlp_ready,
  input  logic                           tlp_done,
  input  logic                           fc_update,
  input  logic [1:0]                     TypeFC,
  input  logic [FC_HDR_WIDTH-1:0]        HdrFC,
  input  logic [FC_DATA_WIDTH-1:0]       DataFC,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic [2:0]                     fc_blocked
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [FC_HDR_WIDTH-1:0]  HDR_HALF  = {1'b1, {(FC_HDR_WIDTH-1){1'b0}}};
  localparam logic [FC_DATA_WIDTH-1:0] DATA_HALF = {1'b1, {(FC_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT_DONE} state_t;

  state_t                   r_state;
  logic [NUM_REQ-1:0]       r_grant;
  logic                     r_busy;
  logic [PW-1:0]            r_rr_ptr;
  logic [FC_HDR_WIDTH-1:0]  r_cl_h [3];
  logic [FC_HDR_WIDTH-1:0]  r_cc_h [3];
  logic [FC_DATA_WIDTH-1:0] r_cl_d [3];
  logic [FC_DATA_WIDTH-1:0] r_cc_d [3];
  logic [2:0]               r_lim_valid;
  logic [2:0]               r_inf_h;
  logic [2:0]               r_inf_d;

  logic [NUM_REQ-1:0]       w_credit_ok;
  logic [NUM_REQ-1:0]       w_elig;
  logic [PW-1:0]            w_winner;
  logic                     w_any;
  logic [1:0]               w_win_type;
  logic [DCRED_WIDTH-1:0]   w_win_dcred;
  logic                     w_take;
  logic [2:0]               w_blocked;

  // Modular credit window: remaining credits must not have wrapped past half range.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [1:0]               w_type;
    logic [1:0]               w_ti;
    logic [DCRED_WIDTH-1:0]   w_dcred;
    logic [FC_HDR_WIDTH-1:0]  w_hdr_rem;
    logic [FC_DATA_WIDTH-1:0] w_data_rem;
    logic                     w_hdr_ok;
    logic                     w_data_ok;

    assign w_type     = req_type[2*gi +: 2];
    assign w_ti       = (w_type == 2'd3) ? 2'd0 : w_type;
    assign w_dcred    = req_dcred[DCRED_WIDTH*gi +: DCRED_WIDTH];
    assign w_hdr_rem  = r_cl_h[w_ti] - r_cc_h[w_ti] - FC_HDR_WIDTH'(1);
    assign w_data_rem = r_cl_d[w_ti] - r_cc_d[w_ti] - FC_DATA_WIDTH'(w_dcred);
    assign w_hdr_ok   = r_inf_h[w_ti] || (w_hdr_rem <= HDR_HALF);
    assign w_data_ok  = (w_dcred == '0) || r_inf_d[w_ti] || (w_data_rem <= DATA_HALF);
    assign w_credit_ok[gi] = (w_type != 2'd3) && r_lim_valid[w_ti] && w_hdr_ok && w_data_ok;
    assign w_elig[gi]      = req_valid[gi] && w_credit_ok[gi];
  end

  always_comb begin
    int idx;
    idx      = 0;
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_any && w_elig[idx]) begin
        w_any    = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !w_credit_ok[i] && (req_type[2*i +: 2] != 2'd3))
        w_blocked[req_type[2*i +: 2]] = 1'b1;
    end
  end

  assign w_win_type  = req_type[2*int'(w_winner) +: 2];
  assign w_win_dcred = req_dcred[DCRED_WIDTH*int'(w_winner) +: DCRED_WIDTH];
  assign w_take      = (r_state == S_IDLE) && tlp_ready && w_any;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_rr_ptr    <= PW'(NUM_REQ - 1);
      r_lim_valid <= '0;
      r_inf_h     <= '0;
      r_inf_d     <= '0;
      for (int t = 0; t < 3; t++) begin
        r_cl_h[t] <= '0;
        r_cc_h[t] <= '0;
        r_cl_d[t] <= '0;
        r_cc_d[t] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state  <= S_GRANT;
            r_grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
            r_busy   <= 1'b1;
            r_rr_ptr <= w_winner;
          end
        end
        S_GRANT: begin
          r_grant <= '0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tlp_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Limit writes and consumption are independent registers, so both land on one edge.
      for (int t = 0; t < 3; t++) begin
        if (fc_update && (TypeFC == 2'(t))) begin
          r_cl_h[t] <= HdrFC;
          r_cl_d[t] <= DataFC;
          if (!r_lim_valid[t]) begin
            r_lim_valid[t] <= 1'b1;
            r_inf_h[t]     <= (HdrFC == '0);
            r_inf_d[t]     <= (DataFC == '0);
          end
        end
        if (w_take && (w_win_type == 2'(t))) begin
          r_cc_h[t] <= r_cc_h[t] + FC_HDR_WIDTH'(1);
          r_cc_d[t] <= r_cc_d[t] + FC_DATA_WIDTH'(w_win_dcred);
        end
      end
    end
  end

  assign grant      = r_grant;
  assign busy       = r_busy;
  assign fc_blocked = w_blocked;

endmodule

// File: doc/tl_tx_fc_scheduler.md
# tl_tx_fc_scheduler

Credit-aware transmit scheduler for the PCIe transaction layer TX path. It sits between the TLP sources and the shared header/data fragmentation path. The sources are: AXI slave write requests, AXI slave read requests, AXI master completions, and Rx-router completions/messages. Each cycle it selects one eligible source by round-robin, where eligible means the DLL has advertised enough flow-control credits for that source's TLP type. It consumes those credits and holds off further grants until the fragmentation path reports the TLP is done.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; index 0 = AXI write, 1 = AXI read, 2 = AXI master completion, 3 = Rx router.
- FC_HDR_WIDTH, 8, header credit counter width (modulo 2^8).
- FC_DATA_WIDTH, 12, data credit counter width (modulo 2^12).
- DCRED_WIDTH, 9, per-request data credit width (max 256 credits = 1024 DW).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- arst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester TLP pending; held until granted.
- req_type  in  2*NUM_REQ  per-requester FC type: 0 = P, 1 = NP, 2 = CPL, 3 = reserved (never eligible).
- req_dcred  in  DCRED_WIDTH*NUM_REQ  data credits needed, ceil(len_dw/4); 0 means no payload.
- tlp_ready  in  1  fragmentation path can accept a new TLP.
- tlp_done  in  1  one-cycle pulse; the granted TLP has been fully handed to the DLL.
- fc_update  in  1  credit-limit update strobe from the DLL.
- TypeFC  in  2  type of the update; same encoding as req_type.
- HdrFC  in  FC_HDR_WIDTH  new header credit limit.
- DataFC  in  FC_DATA_WIDTH  new data credit limit.
- grant  out  NUM_REQ  one-hot, asserted for exactly one cycle per granted TLP.
- busy  out  1  high from the grant cycle through the tlp_done cycle.
- fc_blocked  out  3  per type (bit0 = P, bit1 = NP, bit2 = CPL): high while some requester of that type is valid but ineligible because of credits.

## Operation
Per-type state (P, NP, CPL):
- CL_h / CL_d: credit limits.
- CC_h / CC_d: credits consumed.
- lim_valid: set by the first fc_update for that type.
- inf_h / inf_d: infinite flags, set when that first update carries 0 in the corresponding field.

Limit updates:
- Later updates overwrite CL_h / CL_d.
- Later updates never change inf_h / inf_d.

Eligibility of requester i:
- req_valid[i] is high, lim_valid is set for its type, and the type is not reserved.
- Header check: inf_h is set, or ((CL_h − (CC_h + 1)) mod 2^FC_HDR_WIDTH) ≤ 2^(FC_HDR_WIDTH−1).
- Data check: req_dcred = 0, or inf_d is set, or ((CL_d − (CC_d + req_dcred)) mod 2^FC_DATA_WIDTH) ≤ 2^(FC_DATA_WIDTH−1).
- All subtraction and addition wraps modulo the counter width.

Round-robin:
- Search starts at rr_ptr+1 and wraps at NUM_REQ.
- The first eligible requester wins.
- rr_ptr is set to the winner on grant.

FSM:
- IDLE: if tlp_ready and any requester is eligible, register grant for the winner, then go to GRANT. Otherwise stay in IDLE.
- GRANT: grant is high this cycle. Go to WAIT_DONE.
- WAIT_DONE: when tlp_done is seen, go to IDLE. Otherwise stay.

Credit consumption:
- On the IDLE→GRANT edge, for the winner's type: CC_h += 1 and CC_d += req_dcred (modulo widths).
- Infinite fields still count but are never checked.

Boundary rules:
- tlp_done outside WAIT_DONE is ignored.
- Simultaneous fc_update and grant for the same type: the eligibility check uses the pre-update CL. Both the CL write and the CC increment take effect on the same edge.
- An fc_update with TypeFC = 3 is ignored.
- Requests are never partially granted; a blocked TLP waits and does not block other types (no head-of-line across requesters).
- arst mid-transfer returns the block to IDLE and clears all credit state; the in-flight TLP is abandoned.

## Timing
- Reset values:
  - grant = 0, busy = 0, fc_blocked = 0.
  - State = IDLE, rr_ptr = NUM_REQ−1 (requester 0 searched first).
  - All CL, CC, lim_valid and inf flags = 0.
- Latency:
  - Eligible request in IDLE at edge N → grant high in cycle N+1.
  - Earliest next grant: the cycle after IDLE is re-entered, i.e. two cycles after the tlp_done cycle.
- busy is registered: it is high in GRANT and WAIT_DONE, and low in IDLE.
- fc_blocked is combinational from the registered credit state and the inputs.
- A CL change takes effect on the eligibility check in the cycle after the fc_update edge.

## Test plan
- Init gating: all req_valid high, no fc_update → no grant for 20 cycles. Then fc_update P with Hdr = 0, Data = 0 → only requester 0 (P) is granted and it repeats indefinitely; fc_blocked[0] stays 0.
- Round-robin: all types infinite, requesters 0–3 valid, tlp_done pulsed 3 cycles after each grant → grant order 0, 1, 2, 3, 0; spacing between grants ≥ 2 cycles after each done.
- Header exhaustion: CPL limit Hdr = 2, Data = 100, requesters 2 and 3 request CPL with dcred 1 → two grants, then the third is blocked and fc_blocked[2] = 1. Then update Hdr = 3 → one more grant.
- Data check and wrap: NP limit CC_d = 4090, CL_d = 4 (wrapped), req_dcred = 10 → eligible, granted, and CC_d becomes 4. A following request with req_dcred = 1 is blocked.
- Simultaneous update/grant: fc_update for P on the same edge as a P grant → CC increments, CL takes the new value, and the next eligibility check uses the new limit.
- Reset mid-operation: assert arst during WAIT_DONE → grant = 0, busy = 0, credits cleared, and no grant until the limits are re-initialized.
